// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue interface: fetch-group enqueue side, decode issue side and status.
interface fetch_queue_if #(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int PC_WIDTH     = 32,
  parameter int INSN_WIDTH   = 32
);
  logic                                flush;
  logic [FETCH_WIDTH-1:0]              inValid;
  logic [FETCH_WIDTH-1:0]              inTaken;
  logic [FETCH_WIDTH*PC_WIDTH-1:0]     inPc;
  logic [FETCH_WIDTH*INSN_WIDTH-1:0]   inInsn;
  logic                                inReady;
  logic [DECODE_WIDTH-1:0]             outValid;
  logic [DECODE_WIDTH*PC_WIDTH-1:0]    outPc;
  logic [DECODE_WIDTH*INSN_WIDTH-1:0]  outInsn;
  logic [DECODE_WIDTH-1:0]             outTaken;
  logic                                deqReady;
  logic [$clog2(DEPTH):0]              occupancy;

  modport master (
    output flush, inValid, inTaken, inPc, inInsn, deqReady,
    input  inReady, outValid, outPc, outInsn, outTaken, occupancy
  );

  modport slave (
    input  flush, inValid, inTaken, inPc, inInsn, deqReady,
    output inReady, outValid, outPc, outInsn, outTaken, occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// Multi-lane fetch queue: kills lanes after the first predicted-taken lane, compacts the
// survivors into a circular buffer and issues up to DECODE_WIDTH oldest entries per cycle.
module fetch_queue #(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int PC_WIDTH     = 32,
  parameter int INSN_WIDTH   = 32
) (
  input logic          clk,
  input logic          rstN,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FW_C    = CW'(FETCH_WIDTH);
  localparam logic [CW-1:0] DW_C    = CW'(DECODE_WIDTH);

  logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];
  logic [INSN_WIDTH-1:0] insn_mem [DEPTH];
  logic [DEPTH-1:0]      taken_mem;

  logic [AW-1:0] head_reg, head_next;
  logic [AW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;

  logic [FETCH_WIDTH-1:0] kept;
  logic [AW-1:0]          slot_off [FETCH_WIDTH];
  logic [AW-1:0]          wr_addr  [FETCH_WIDTH];
  logic                   enq_blocked;
  logic [CW-1:0]          enq_count;
  logic [CW-1:0]          deq_count;
  logic                   in_ready;
  logic                   enq_fire;

  // Each kept lane lands at tail plus the number of kept lanes below it.
  always_comb begin
    kept        = '0;
    enq_blocked = 1'b0;
    enq_count   = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      kept[i]     = bus.inValid[i] & ~enq_blocked;
      slot_off[i] = enq_count[AW-1:0];
      enq_count   = enq_count + CW'(kept[i]);
      enq_blocked = enq_blocked | (bus.inValid[i] & bus.inTaken[i]);
    end
  end

  assign in_ready  = (DEPTH_C - count_reg) >= FW_C;
  assign enq_fire  = in_ready && (enq_count != '0);
  assign deq_count = !bus.deqReady ? '0 : ((count_reg > DW_C) ? DW_C : count_reg);

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (bus.flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      head_next = head_reg + deq_count[AW-1:0];
      if (enq_fire) begin
        tail_next  = tail_reg + enq_count[AW-1:0];
        count_next = count_reg + enq_count - deq_count;
      end else begin
        count_next = count_reg - deq_count;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_wr
      assign wr_addr[gi] = tail_reg + slot_off[gi];
    end
  endgenerate

  // Storage is not reset; count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (enq_fire && kept[i]) begin
        pc_mem[wr_addr[i]]    <= bus.inPc[i*PC_WIDTH +: PC_WIDTH];
        insn_mem[wr_addr[i]]  <= bus.inInsn[i*INSN_WIDTH +: INSN_WIDTH];
        taken_mem[wr_addr[i]] <= bus.inTaken[i];
      end
    end
  end

  generate
    for (gi = 0; gi < DECODE_WIDTH; gi++) begin : g_rd
      logic [AW-1:0] rd_addr;
      logic          lane_valid;
      assign rd_addr    = head_reg + AW'(gi);
      assign lane_valid = count_reg > CW'(gi);
      assign bus.outValid[gi] = lane_valid;
      assign bus.outPc[gi*PC_WIDTH +: PC_WIDTH]       = lane_valid ? pc_mem[rd_addr] : '0;
      assign bus.outInsn[gi*INSN_WIDTH +: INSN_WIDTH] = lane_valid ? insn_mem[rd_addr] : '0;
      assign bus.outTaken[gi] = lane_valid ? taken_mem[rd_addr] : 1'b0;
    end
  endgenerate

  assign bus.inReady   = in_ready;
  assign bus.occupancy = count_reg;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; expected entries go to a scoreboard that a monitor
// process drains whenever the queue issues to decode.
module tb_fetch_queue;
  localparam int FW = 2;
  localparam int DW = 2;
  localparam int DEPTH = 8;
  localparam int PW = 32;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rstN;

  fetch_queue_if #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH),
                   .PC_WIDTH(PW), .INSN_WIDTH(IW)) bus ();

  fetch_queue #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH),
                .PC_WIDTH(PW), .INSN_WIDTH(IW)) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          errors = 0;
  int          g;
  logic [31:0] base;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] t, input logic [31:0] p0,
                       input logic [31:0] p1, input logic dq, input logic fl);
    bus.inValid  = v;
    bus.inTaken  = t;
    bus.inPc     = {p1, p0};
    bus.inInsn   = {~p1, ~p0};
    bus.deqReady = dq;
    bus.flush    = fl;
  endtask

  task automatic idle(input logic dq);
    drive(2'b00, 2'b00, 32'h0, 32'h0, dq, 1'b0);
  endtask

  task automatic expect_entry(input logic [31:0] p, input logic tk);
    sb.push_back('{pc: p, taken: tk});
    $display("[TB] enq pc=%08h taken=%0d", p, tk);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Dequeued lanes are those shown while deqReady is high at the sampling edge.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      check("outvalid_thermo", {63'd0, bus.outValid[1] & ~bus.outValid[0]}, 64'd0);
      for (int i = 0; i < DW; i++) begin
        if (!bus.outValid[i]) begin
          check($sformatf("idle_lane%0d", i),
                {bus.outPc[i*PW +: PW], bus.outInsn[i*IW +: IW] | {31'd0, bus.outTaken[i]}}, 64'd0);
        end else if (rstN && bus.deqReady && !bus.flush) begin
          if (sb.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL deq_unexpected: got pc %08h, expected no entry", bus.outPc[i*PW +: PW]);
          end else begin
            e = sb.pop_front();
            $display("[TB] deq lane%0d pc=%08h taken=%0d", i, bus.outPc[i*PW +: PW], bus.outTaken[i]);
            check("deq_pc", {32'd0, bus.outPc[i*PW +: PW]}, {32'd0, e.pc});
            check("deq_insn", {32'd0, bus.outInsn[i*IW +: IW]}, {32'd0, ~e.pc});
            check("deq_taken", {63'd0, bus.outTaken[i]}, {63'd0, e.taken});
          end
        end
      end
    end
  endtask

  initial begin
    rstN = 1'b1;
    idle(1'b0);
    fork
      monitor();
    join_none

    #2 rstN = 1'b0;
    #1;
    check("rst_inready", {63'd0, bus.inReady}, 64'd1);
    check("rst_outvalid", {62'd0, bus.outValid}, 64'd0);
    check("rst_occ", {60'd0, bus.occupancy}, 64'd0);
    #8 rstN = 1'b1;
    cyc();

    // Plain two-lane group, then drain it.
    drive(2'b11, 2'b00, 32'h1000, 32'h1004, 1'b0, 1'b0);
    expect_entry(32'h1000, 1'b0);
    expect_entry(32'h1004, 1'b0);
    cyc();
    idle(1'b0);
    check("basic_occ", {60'd0, bus.occupancy}, 64'd2);
    check("basic_valid", {62'd0, bus.outValid}, 64'd3);
    check("basic_pc", bus.outPc, 64'h00001004_00001000);
    check("basic_taken", {62'd0, bus.outTaken}, 64'd0);
    idle(1'b1);
    cyc();
    idle(1'b0);
    check("basic_drain", {60'd0, bus.occupancy}, 64'd0);

    // Lane 0 taken kills lane 1.
    drive(2'b11, 2'b01, 32'h2000, 32'h2004, 1'b0, 1'b0);
    expect_entry(32'h2000, 1'b1);
    cyc();
    idle(1'b0);
    check("taken0_occ", {60'd0, bus.occupancy}, 64'd1);
    check("taken0_valid", {62'd0, bus.outValid}, 64'd1);
    check("taken0_flag", {62'd0, bus.outTaken}, 64'd1);

    // Lane 1 taken keeps both; same-cycle dequeue of the lone entry.
    drive(2'b11, 2'b10, 32'h2100, 32'h2104, 1'b1, 1'b0);
    expect_entry(32'h2100, 1'b0);
    expect_entry(32'h2104, 1'b1);
    cyc();
    drive(2'b11, 2'b11, 32'h2200, 32'h2204, 1'b0, 1'b0);
    expect_entry(32'h2200, 1'b1);
    check("enq_deq_occ", {60'd0, bus.occupancy}, 64'd2);
    cyc();
    idle(1'b0);
    check("both_taken_occ", {60'd0, bus.occupancy}, 64'd3);

    // Holes: invalid lane 0 (taken or not) is skipped and lane 1 is compacted.
    drive(2'b10, 2'b00, 32'h3000, 32'h3004, 1'b1, 1'b0);
    expect_entry(32'h3004, 1'b0);
    cyc();
    drive(2'b10, 2'b01, 32'h3100, 32'h3104, 1'b0, 1'b0);
    expect_entry(32'h3104, 1'b0);
    cyc();
    idle(1'b0);
    check("hole_occ", {60'd0, bus.occupancy}, 64'd3);
    check("hole_pc", bus.outPc, 64'h00003004_00002200);
    idle(1'b1);
    cyc();
    cyc();
    idle(1'b0);
    check("hole_drain", {60'd0, bus.occupancy}, 64'd0);

    // Back-pressure: fill to 7, an extra group must be ignored.
    drive(2'b11, 2'b00, 32'h4000, 32'h4004, 1'b0, 1'b0);
    expect_entry(32'h4000, 1'b0);
    expect_entry(32'h4004, 1'b0);
    cyc();
    drive(2'b11, 2'b00, 32'h4008, 32'h400c, 1'b0, 1'b0);
    expect_entry(32'h4008, 1'b0);
    expect_entry(32'h400c, 1'b0);
    cyc();
    drive(2'b11, 2'b00, 32'h4010, 32'h4014, 1'b0, 1'b0);
    expect_entry(32'h4010, 1'b0);
    expect_entry(32'h4014, 1'b0);
    cyc();
    check("bp_occ6", {60'd0, bus.occupancy}, 64'd6);
    check("bp_ready6", {63'd0, bus.inReady}, 64'd1);
    drive(2'b01, 2'b00, 32'h4018, 32'h401c, 1'b0, 1'b0);
    expect_entry(32'h4018, 1'b0);
    cyc();
    check("bp_occ7", {60'd0, bus.occupancy}, 64'd7);
    check("bp_ready7", {63'd0, bus.inReady}, 64'd0);
    drive(2'b11, 2'b00, 32'h4020, 32'h4024, 1'b0, 1'b0);
    cyc();
    idle(1'b0);
    check("bp_ignored", {60'd0, bus.occupancy}, 64'd7);
    idle(1'b1);
    cyc();
    idle(1'b0);
    check("bp_occ5", {60'd0, bus.occupancy}, 64'd5);
    check("bp_ready5", {63'd0, bus.inReady}, 64'd1);
    idle(1'b1);
    repeat (3) cyc();
    idle(1'b0);
    check("bp_drain", {60'd0, bus.occupancy}, 64'd0);

    // Wrap-around: 20 sequential groups with deqReady toggling.
    g = 0;
    for (int c = 0; c < 200 && g < 20; c++) begin
      base = 32'h5000 + 32'(g) * 32'd8;
      drive(2'b11, 2'b00, base, base + 32'd4, c[0], 1'b0);
      if (bus.inReady) begin
        expect_entry(base, 1'b0);
        expect_entry(base + 32'd4, 1'b0);
        g++;
      end
      cyc();
    end
    check("wrap_groups", 64'(g), 64'd20);
    idle(1'b1);
    for (int c = 0; c < 40 && bus.occupancy != 0; c++) cyc();
    idle(1'b0);
    check("wrap_drain", {60'd0, bus.occupancy}, 64'd0);
    check("wrap_sb_empty", 64'(sb.size()), 64'd0);

    // Flush at occupancy 6 with a concurrent group and dequeue.
    drive(2'b11, 2'b00, 32'h6000, 32'h6004, 1'b0, 1'b0);
    cyc();
    drive(2'b11, 2'b00, 32'h6008, 32'h600c, 1'b0, 1'b0);
    cyc();
    drive(2'b11, 2'b00, 32'h6010, 32'h6014, 1'b0, 1'b0);
    cyc();
    check("flush_pre_occ", {60'd0, bus.occupancy}, 64'd6);
    drive(2'b11, 2'b00, 32'h7000, 32'h7004, 1'b1, 1'b1);
    cyc();
    idle(1'b0);
    check("flush_occ", {60'd0, bus.occupancy}, 64'd0);
    check("flush_valid", {62'd0, bus.outValid}, 64'd0);
    check("flush_ready", {63'd0, bus.inReady}, 64'd1);

    drive(2'b11, 2'b00, 32'h8000, 32'h8004, 1'b0, 1'b0);
    expect_entry(32'h8000, 1'b0);
    expect_entry(32'h8004, 1'b0);
    cyc();
    idle(1'b0);
    check("post_flush_pc", bus.outPc, 64'h00008004_00008000);

    // Asynchronous reset between clock edges.
    #2 rstN = 1'b0;
    #1;
    sb.delete();
    check("async_rst_occ", {60'd0, bus.occupancy}, 64'd0);
    check("async_rst_valid", {62'd0, bus.outValid}, 64'd0);
    check("async_rst_ready", {63'd0, bus.inReady}, 64'd1);
    #2 rstN = 1'b1;
    cyc();

    drive(2'b01, 2'b00, 32'h9000, 32'h9004, 1'b0, 1'b0);
    expect_entry(32'h9000, 1'b0);
    cyc();
    idle(1'b1);
    cyc();
    idle(1'b0);
    check("final_occ", {60'd0, bus.occupancy}, 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised multi-lane instruction buffer between the fetch stage and the pre-decode stage.
- Fetch-group width and decode width are independent; i-cache miss stalls and decode back-pressure are absorbed here instead of stalling the whole front end.
- Per-lane branch-prediction masking:
  - lanes after the first predicted-taken lane are killed;
  - surviving lanes are compacted;
  - stored in a circular buffer and issued in program order.
- Adds behaviour the current fetch stage lacks: a dequeue width that differs from the fetch width, buffering depth, and group compaction.

Parameters:
FETCH_WIDTH, 2, instructions per enqueued fetch group (1..4)
DECODE_WIDTH, 2, max instructions issued per cycle (1..4)
DEPTH, 8, entries; power of two, >= FETCH_WIDTH + DECODE_WIDTH
PC_WIDTH, 32, bits per PC
INSN_WIDTH, 32, bits per instruction word

Ports:
clk  in  1  clock; all state on rising edge
rstN  in  1  asynchronous active-low reset
flush  in  1  synchronous clear (branch mispredict / recovery)
inValid  in  FETCH_WIDTH  per-lane valid of fetch group
inTaken  in  FETCH_WIDTH  per-lane predicted-taken (BTB or decided)
inPc  in  FETCH_WIDTH*PC_WIDTH  lane PCs, lane 0 in LSBs
inInsn  in  FETCH_WIDTH*INSN_WIDTH  lane instruction words
inReady  out  1  queue can accept a full group this cycle
outValid  out  DECODE_WIDTH  per-lane output valid, thermometer-coded from lane 0
outPc  out  DECODE_WIDTH*PC_WIDTH  PCs of oldest entries
outInsn  out  DECODE_WIDTH*INSN_WIDTH  instruction words of oldest entries
outTaken  out  DECODE_WIDTH  predicted-taken flag of each output entry
deqReady  in  1  consumer accepts all asserted outValid lanes this cycle
occupancy  out  log2(DEPTH)+1  current entry count

Behaviour:
- State:
  - storage array of DEPTH x {pc, insn, taken};
  - head and tail pointers, log2(DEPTH) bits, wrap modulo DEPTH;
  - count register, log2(DEPTH)+1 bits.
- Reset (rstN low, asynchronous):
  - head = tail = count = 0;
  - inReady = 1, outValid = 0, occupancy = 0;
  - storage contents are don't-care.
- Lane masking (combinational):
  - kept[i] = inValid[i] and no lane j < i has inValid[j] and inTaken[j];
  - the taken lane itself is kept.
- Compaction:
  - kept lanes are written to consecutive slots tail, tail+1, ... in ascending lane order;
  - invalid holes are skipped;
  - enqCount = popcount(kept).
- inReady = (DEPTH - count) >= FETCH_WIDTH; combinational from registered count only (no dependency on deqReady).
- Enqueue fires when inReady and enqCount > 0. With inReady low, inputs are ignored; the upstream stage holds the group and stalls.
- Output (combinational from registers):
  - outValid[i] = (count > i);
  - lane i shows entry head+i mod DEPTH;
  - invalid output lanes drive 0 on pc/insn/taken.
- Dequeue:
  - when deqReady, deqCount = min(count, DECODE_WIDTH) entries are removed;
  - deqReady with count = 0 is a no-op.
- No bypass: an entry enqueued in cycle N is first visible on the outputs in cycle N+1. Minimum latency is 1 cycle.
- Same-cycle enqueue and dequeue:
  - count_next = count + enqCount - deqCount;
  - deqCount uses the pre-enqueue count;
  - count never exceeds DEPTH, guaranteed by the inReady rule.
- Pointers: tail += enqCount, head += deqCount, both mod DEPTH; writes and reads split correctly across the wrap boundary.
- Flush:
  - synchronous; next cycle head = tail = count = 0;
  - any enqueue or dequeue in the flush cycle is discarded;
  - flush has priority over everything except reset.
- Reset asserted mid-operation clears state immediately, regardless of clk.
- occupancy = count (registered).

Test Plan:
- Reset, then FETCH_WIDTH=2 group {pc 0x1000, 0x1004} both valid, not taken -> next cycle outValid=2'b11, outPc={0x1004,0x1000}, occupancy=2.
- inValid=2'b11, inTaken=2'b01 (lane 0 taken) -> only 0x2000 enqueued, occupancy=1, outTaken[0]=1.
- Hole compaction with FETCH_WIDTH=4, inValid=4'b1010, no taken -> lane1 and lane3 PCs land in consecutive entries, occupancy=2.
- Back-pressure: enqueue groups with deqReady=0 until occupancy=7 (DEPTH=8) -> inReady=0; the next group is ignored and occupancy stays 7; one deqReady cycle -> occupancy=5, inReady=1.
- Wrap-around: 20 groups with sequential PCs, deqReady toggling 1/0 -> output PC stream strictly increasing by 4 with no loss or duplication across pointer wrap.
- Flush with occupancy=6 and a simultaneous valid group and deqReady=1 -> next cycle occupancy=0, outValid=0, inReady=1; rstN pulsed low between clock edges -> outputs clear immediately.
